// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipelined MIPS front end.
//   PIPE_RESET_PC : default PC loaded on reset
//   INST_NOP      : instruction word used for an empty IF/ID register
//   if_state_t    : fetch controller states (FETCH, WAIT, HOLD)
//   if_id_t       : IF/ID bundle (pc, pc4, inst, valid), also consumed by ID
//   word_align()  : clears the byte-offset bits of an address
// ---------------------------------------------------------------------------
package pipe_pkg;

  localparam logic [31:0] PIPE_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] INST_NOP      = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } if_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] inst;
    logic        valid;
  } if_id_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/pipe_ifid_reg.sv
// ---------------------------------------------------------------------------
// pipe_ifid_reg
// IF/ID pipeline register with flush, hold and load controls.
// Priority: flush (valid cleared) > hold (keep everything) > load (capture
// i_d) > otherwise a bubble (valid cleared, payload kept).
// Ports:
//   clk, clrn : clock, asynchronous active-low reset
//   i_load    : capture i_d
//   i_flush   : squash the held instruction
//   i_hold    : downstream stall, keep the current contents
//   i_d       : incoming IF/ID bundle
//   o_q       : registered IF/ID bundle
// ---------------------------------------------------------------------------
module pipe_ifid_reg
  import pipe_pkg::*;
(
  input  logic   clk,
  input  logic   clrn,
  input  logic   i_load,
  input  logic   i_flush,
  input  logic   i_hold,
  input  if_id_t i_d,
  output if_id_t o_q
);

  if_id_t r_q;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_q <= '{pc: 32'd0, pc4: 32'd0, inst: INST_NOP, valid: 1'b0};
    end else if (i_flush) begin
      r_q.valid <= 1'b0;
    end else if (!i_hold) begin
      if (i_load) begin
        r_q <= i_d;
      end else begin
        r_q.valid <= 1'b0;
      end
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_if_stage.sv
// ---------------------------------------------------------------------------
// pipe_if_stage
// Instruction-fetch stage plus IF/ID register. Holds the PC, fetches words
// over a req/ack handshake, parks an acked word while ID stalls, and applies
// branch/jump redirects from ID (one wrong-path slot is squashed).
// Optional feature macro: PIPE_IF_PERF_EN adds fetch_cnt / stall_cnt.
// Ports:
//   clk, clrn        : clock, asynchronous active-low reset
//   id_stall         : ID cannot accept an instruction, IF/ID holds
//   redirect         : taken branch / jump from ID (single-cycle pulse)
//   redirect_pc      : redirect target (low two bits ignored)
//   imem_req         : fetch request (low only while a word is parked)
//   imem_addr        : fetch address
//   imem_ack         : response strobe, imem_rdata valid this cycle
//   imem_rdata       : fetched instruction word
//   pc               : current PC register
//   if_pc/if_pc4     : address (and address+4) of the IF/ID instruction
//   if_inst          : IF/ID instruction word
//   if_valid         : IF/ID holds a real instruction
//   fetch_cnt        : (PIPE_IF_PERF_EN) valid IF/ID loads
//   stall_cnt        : (PIPE_IF_PERF_EN) cycles spent in WAIT or HOLD
// ---------------------------------------------------------------------------
module pipe_if_stage
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PIPE_RESET_PC
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        id_stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic [31:0] if_inst,
  output logic        if_valid
`ifdef PIPE_IF_PERF_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
`endif
);

  if_state_t   r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt, w_pc_plus4;
  logic        r_drop, w_drop_nxt, w_drop_set;
  logic [31:0] r_old_addr;
  logic [31:0] r_buf_pc, r_buf_inst;
  logic        w_park, w_load;
  if_id_t      w_ifid_d, w_ifid_q;

  assign w_pc_plus4 = r_pc + 32'd4;
  // The drop flag is armed only on the cycle it first becomes set; a second
  // redirect while a drop is pending keeps the original outstanding address.
  assign w_drop_set = w_drop_nxt && !r_drop;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_drop_nxt  = r_drop;
    w_park      = 1'b0;
    w_load      = 1'b0;
    w_ifid_d    = '{pc: r_pc, pc4: w_pc_plus4, inst: imem_rdata, valid: 1'b1};

    if (redirect) begin
      // Any ack this cycle belongs to the wrong path and is discarded. A
      // request still outstanding must be drained before the new target.
      w_state_nxt = FETCH;
      w_pc_nxt    = word_align(redirect_pc);
      w_drop_nxt  = ((r_state == WAIT) || r_drop) && !imem_ack;
    end else begin
      case (r_state)
        HOLD: begin
          if (!id_stall) begin
            w_load      = 1'b1;
            w_ifid_d    = '{pc: r_buf_pc, pc4: w_pc_plus4, inst: r_buf_inst, valid: 1'b1};
            w_pc_nxt    = w_pc_plus4;
            w_state_nxt = FETCH;
          end
        end
        default: begin
          if (imem_ack && r_drop) begin
            // Stale response of the pre-redirect request: consume and ignore.
            w_drop_nxt  = 1'b0;
            w_state_nxt = FETCH;
          end else if (imem_ack) begin
            if (!id_stall) begin
              w_load      = 1'b1;
              w_pc_nxt    = w_pc_plus4;
              w_state_nxt = FETCH;
            end else begin
              w_park      = 1'b1;
              w_state_nxt = HOLD;
            end
          end else begin
            w_state_nxt = WAIT;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state    <= FETCH;
      r_pc       <= RESET_PC;
      r_drop     <= 1'b0;
      r_old_addr <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_drop  <= w_drop_nxt;
      if (w_drop_set) begin
        r_old_addr <= r_pc;
      end
    end
  end

  // Park buffer: payload only, its occupancy is the HOLD state.
  always_ff @(posedge clk) begin
    if (w_park) begin
      r_buf_pc   <= r_pc;
      r_buf_inst <= imem_rdata;
    end
  end

  pipe_ifid_reg u_ifid (
    .clk     (clk),
    .clrn    (clrn),
    .i_load  (w_load),
    .i_flush (redirect),
    .i_hold  (id_stall),
    .i_d     (w_ifid_d),
    .o_q     (w_ifid_q)
  );

`ifdef PIPE_IF_PERF_EN
  logic [31:0] r_fetch_cnt, r_stall_cnt;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_fetch_cnt <= 32'd0;
      r_stall_cnt <= 32'd0;
    end else begin
      if (w_load) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
      if (r_state != FETCH) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign fetch_cnt = r_fetch_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

  // While a drop is pending the old address stays on the bus until its ack.
  assign imem_req  = (r_state != HOLD);
  assign imem_addr = r_drop ? r_old_addr : r_pc;
  assign pc        = r_pc;
  assign if_pc     = w_ifid_q.pc;
  assign if_pc4    = w_ifid_q.pc4;
  assign if_inst   = w_ifid_q.inst;
  assign if_valid  = w_ifid_q.valid;

endmodule

// File: tb/tb_pipe_if_stage.sv
// ---------------------------------------------------------------------------
// tb_pipe_if_stage
// Self-checking bench for pipe_if_stage: a behavioural memory with variable
// latency, a behavioural model of the fetch rules, directed scenarios with
// literal expectations, then randomized stall/redirect/latency/reset traffic.
// ---------------------------------------------------------------------------
module tb_pipe_if_stage;

  logic        clk = 1'b0;
  logic        clrn;
  logic        id_stall, redirect, imem_ack;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, if_valid;
  logic [31:0] imem_addr, pc, if_pc, if_pc4, if_inst;
`ifdef PIPE_IF_PERF_EN
  logic [31:0] fetch_cnt, stall_cnt;
`endif

  pipe_if_stage dut (
    .clk         (clk),
    .clrn        (clrn),
    .id_stall    (id_stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .pc          (pc),
    .if_pc       (if_pc),
    .if_pc4      (if_pc4),
    .if_inst     (if_inst),
    .if_valid    (if_valid)
`ifdef PIPE_IF_PERF_EN
    ,
    .fetch_cnt   (fetch_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  localparam logic [1:0] M_ISSUE = 2'd0;  // request being issued
  localparam logic [1:0] M_WAIT  = 2'd1;  // request outstanding
  localparam logic [1:0] M_PARK  = 2'd2;  // acked word parked for stalled ID

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  mode;
    logic        drop;
    logic [31:0] old;
    logic [31:0] bpc;
    logic [31:0] binst;
    logic [31:0] ipc;
    logic [31:0] ipc4;
    logic [31:0] iinst;
    logic        ival;
    logic [31:0] fcnt;
    logic [31:0] scnt;
  } mst_t;

  mst_t m_cur, m_nxt;

  function automatic mst_t mreset();
    mst_t r;
    r = '0;
    return r;
  endfunction

  function automatic mst_t mstep(input mst_t c, input bit rstn, input bit stall,
                                 input bit redir, input logic [31:0] rpc,
                                 input bit ack, input logic [31:0] rdata);
    mst_t n;
    logic [31:0] bus_addr;
    if (!rstn) return mreset();
    n = c;
    bus_addr = c.drop ? c.old : c.pc;
    if (c.mode != M_ISSUE) n.scnt = c.scnt + 1;
    if (redir) begin
      n.pc   = {rpc[31:2], 2'b00};
      n.ival = 1'b0;
      n.mode = M_ISSUE;
      n.drop = (c.mode == M_WAIT || c.drop) && !ack;
      if (n.drop) n.old = bus_addr;
    end else if (c.mode == M_PARK) begin
      if (!stall) begin
        n.ipc = c.bpc; n.ipc4 = c.bpc + 4; n.iinst = c.binst; n.ival = 1'b1;
        n.fcnt = c.fcnt + 1; n.pc = c.pc + 4; n.mode = M_ISSUE;
      end
    end else if (ack && c.drop) begin
      n.drop = 1'b0; n.mode = M_ISSUE;
      if (!stall) n.ival = 1'b0;
    end else if (ack) begin
      if (!stall) begin
        n.ipc = c.pc; n.ipc4 = c.pc + 4; n.iinst = rdata; n.ival = 1'b1;
        n.fcnt = c.fcnt + 1; n.pc = c.pc + 4; n.mode = M_ISSUE;
      end else begin
        n.bpc = c.pc; n.binst = rdata; n.mode = M_PARK;
      end
    end else begin
      n.mode = M_WAIT;
      if (!stall) n.ival = 1'b0;
    end
    return n;
  endfunction

  // One compare process, every cycle, on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("imem_req", 32'(imem_req), 32'(m_cur.mode != M_PARK));
      chk("imem_addr", imem_addr, m_cur.drop ? m_cur.old : m_cur.pc);
      chk("pc", pc, m_cur.pc);
      chk("if_valid", 32'(if_valid), 32'(m_cur.ival));
      if (m_cur.ival) begin
        chk("if_pc", if_pc, m_cur.ipc);
        chk("if_pc4", if_pc4, m_cur.ipc4);
        chk("if_inst", if_inst, m_cur.iinst);
      end
`ifdef PIPE_IF_PERF_EN
      chk("fetch_cnt", fetch_cnt, m_cur.fcnt);
      chk("stall_cnt", stall_cnt, m_cur.scnt);
`endif
    end
  end

  // ---------------- behavioural memory ----------------
  bit          mem_pend = 1'b0;
  logic [31:0] mem_addr = '0;
  int          mem_left = 0;
  int          mem_lat  = 0;   // <0 selects a random latency per request

  function automatic logic [31:0] memword(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, ~a[31:16]};
  endfunction

  function automatic int pick_lat();
    int r;
    r = $urandom_range(0, 9);
    if (r < 5) return 0;
    if (r < 8) return 1;
    if (r < 9) return 2;
    return 4;
  endfunction

  task automatic mem_respond(output logic ack, output logic [31:0] rd);
    ack = 1'b0;
    rd  = $urandom;
    if (!clrn || !imem_req) begin
      mem_pend = 1'b0;
    end else begin
      if (!mem_pend || mem_addr != imem_addr) begin
        mem_pend = 1'b1;
        mem_addr = imem_addr;
        mem_left = (mem_lat >= 0) ? mem_lat : pick_lat();
      end
      if (mem_left == 0) begin
        ack = 1'b1; rd = memword(mem_addr); mem_pend = 1'b0;
      end else begin
        mem_left--;
      end
    end
  endtask

  // Called just after a rising edge; drives one cycle and returns #1 after
  // the next rising edge.
  task automatic cycle(input bit stall, input bit redir, input logic [31:0] rpc);
    logic        ack;
    logic [31:0] rd;
    id_stall    = stall;
    redirect    = redir;
    redirect_pc = rpc;
    mem_respond(ack, rd);
    imem_ack    = ack;
    imem_rdata  = rd;
    m_nxt = mstep(m_cur, clrn, stall, redir, rpc, ack, rd);
    @(posedge clk);
    m_cur = m_nxt;
    #1;
  endtask

  task automatic pulse_reset();
    clrn     = 1'b0;
    m_cur    = mreset();
    mem_pend = 1'b0;
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    clrn = 1'b1; id_stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_ack = 1'b0; imem_rdata = '0;
    m_cur = mreset(); m_nxt = mreset();
    #2;
    clrn   = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst pc", pc, 32'h0);
    chk("rst if_valid", 32'(if_valid), 32'h0);
    chk("rst if_pc", if_pc, 32'h0);
    chk("rst if_pc4", if_pc4, 32'h0);
    chk("rst if_inst", if_inst, 32'h0);
    clrn = 1'b1;
    chk("rel imem_req", 32'(imem_req), 32'h1);
    chk("rel imem_addr", imem_addr, 32'h0);

    // Zero-wait memory: one instruction per cycle.
    mem_lat = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 32'h0);
      chk("zw if_valid", 32'(if_valid), 32'h1);
      chk("zw if_pc", if_pc, 32'(4 * i));
      chk("zw if_pc4", if_pc4, 32'(4 * i + 4));
      chk("zw imem_req", 32'(imem_req), 32'h1);
    end

    // Two-cycle ack delay at 0x10.
    mem_lat = 2;
    chk("dly addr0", imem_addr, 32'h10);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b0, 32'h0);
      chk("dly bubble", 32'(if_valid), 32'h0);
      chk("dly addr", imem_addr, 32'h10);
    end
    cycle(1'b0, 1'b0, 32'h0);
    chk("dly valid", 32'(if_valid), 32'h1);
    chk("dly if_pc", if_pc, 32'h10);
    chk("dly if_inst", if_inst, memword(32'h10));

    // ID stall while the ack arrives.
    mem_lat = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 32'h0);
      chk("hold req", 32'(imem_req), 32'h0);
      chk("hold if_pc", if_pc, 32'h10);
      chk("hold valid", 32'(if_valid), 32'h1);
    end
    cycle(1'b0, 1'b0, 32'h0);
    chk("unpark if_pc", if_pc, 32'h14);
    chk("unpark if_inst", if_inst, memword(32'h14));
    chk("unpark addr", imem_addr, 32'h18);
    chk("unpark req", 32'(imem_req), 32'h1);

    // Redirect while waiting; stale ack one cycle later.
    mem_lat = 2;
    cycle(1'b0, 1'b0, 32'h0);
    chk("rdw addr", imem_addr, 32'h18);
    mem_lat = 0;
    cycle(1'b0, 1'b1, 32'h200);
    chk("rdw flush", 32'(if_valid), 32'h0);
    chk("rdw held addr", imem_addr, 32'h18);
    chk("rdw pc", pc, 32'h200);
    cycle(1'b0, 1'b0, 32'h0);
    chk("rdw dropped", 32'(if_valid), 32'h0);
    chk("rdw new addr", imem_addr, 32'h200);
    cycle(1'b0, 1'b0, 32'h0);
    chk("rdw first valid", 32'(if_valid), 32'h1);
    chk("rdw first pc", if_pc, 32'h200);
    chk("rdw first inst", if_inst, memword(32'h200));

    // Redirect together with id_stall, misaligned target.
    cycle(1'b1, 1'b1, 32'h1007);
    chk("rds flush", 32'(if_valid), 32'h0);
    chk("rds pc", pc, 32'h1004);
    cycle(1'b0, 1'b0, 32'h0);
    chk("rds if_pc", if_pc, 32'h1004);

    // Reset pulsed in the middle of a wait.
    mem_lat = 3;
    cycle(1'b0, 1'b0, 32'h0);
    chk("mrst wait addr", imem_addr, 32'h1008);
    pulse_reset();
    chk("mrst pc", pc, 32'h0);
    chk("mrst if_valid", 32'(if_valid), 32'h0);
    chk("mrst if_pc", if_pc, 32'h0);
    chk("mrst if_pc4", if_pc4, 32'h0);
    chk("mrst if_inst", if_inst, 32'h0);
`ifdef PIPE_IF_PERF_EN
    chk("mrst fetch_cnt", fetch_cnt, 32'h0);
    chk("mrst stall_cnt", stall_cnt, 32'h0);
`endif
    cycle(1'b0, 1'b0, 32'h0);
    clrn = 1'b1;
    chk("mrst req", 32'(imem_req), 32'h1);
    mem_lat = 0;
    cycle(1'b0, 1'b0, 32'h0);
    chk("mrst restart pc", if_pc, 32'h0);
    chk("mrst restart valid", 32'(if_valid), 32'h1);

    // PC wrap at the top of the address space.
    cycle(1'b0, 1'b1, 32'hFFFF_FFFE);
    cycle(1'b0, 1'b0, 32'h0);
    chk("wrap if_pc", if_pc, 32'hFFFF_FFFC);
    chk("wrap if_pc4", if_pc4, 32'h0);
    chk("wrap pc", pc, 32'h0);

    // Randomized traffic.
    mem_lat = -1;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      bit          st, rd;
      if ($urandom_range(0, 499) == 0) begin
        pulse_reset();
        cycle(1'($urandom_range(0, 1)), 1'b0, 32'h0);
        clrn = 1'b1;
      end
      st  = ($urandom_range(0, 99) < 25);
      rd  = ($urandom_range(0, 99) < 6);
      rpc = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : ($urandom & 32'h0000_FFFF);
      cycle(st, rd, rpc);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_if_stage.md
# pipe_if_stage

Instruction-fetch stage and IF/ID pipeline register for the 5-stage pipelined MIPS CPU. It holds the PC and issues word fetches to instruction memory over a req/ack handshake. It applies branch/jump redirects and stalls from the decode stage, and presents one instruction per cycle to ID with a valid flag. It sits directly upstream of decode and replaces the free-running PC/IM path, so that multi-cycle instruction memory and load-use stalls are handled cleanly.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- clrn  in  1  asynchronous, active-low reset.
- id_stall  in  1  ID cannot accept a new instruction this cycle; the IF/ID register holds.
- redirect  in  1  branch taken or jump resolved in ID; single-cycle pulse.
- redirect_pc  in  32  target address; valid when redirect=1.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address, word aligned.
- imem_ack  in  1  response strobe; rdata is valid in this cycle.
- imem_rdata  in  32  fetched instruction word.
- pc  out  32  address of the next fetch (current PC register).
- if_pc  out  32  address of the instruction in IF/ID.
- if_pc4  out  32  if_pc + 4.
- if_inst  out  32  instruction in IF/ID.
- if_valid  out  1  IF/ID holds a real instruction (0 = bubble).

## Operation
- States:
  - FETCH: imem_req=1 and imem_addr=pc.
  - WAIT: request outstanding; imem_req stays 1 and imem_addr stays stable until ack.
  - HOLD: a word was acked but ID stalled; the word is parked in a one-entry buffer.
- FETCH/WAIT with ack and !id_stall:
  - Load IF/ID with pc, pc+4, rdata and valid=1.
  - pc ← pc+4.
  - Next state is FETCH.
- FETCH/WAIT with ack and id_stall:
  - Park rdata and pc in the buffer.
  - IF/ID is unchanged; go to HOLD.
- FETCH/WAIT without ack:
  - Go to (or stay in) WAIT.
  - If !id_stall, IF/ID.valid ← 0 (bubble); otherwise IF/ID holds.
- HOLD with !id_stall:
  - Move the buffer into IF/ID; pc ← pc+4; go to FETCH.
  - imem_req=0 while in HOLD.
- redirect=1 (priority over everything else):
  - pc ← redirect_pc and IF/ID.valid ← 0 (flush), regardless of id_stall.
  - The buffer is discarded and the state goes to FETCH.
  - If the state was WAIT without ack this cycle, set the drop flag. The next ack is consumed and dropped while the old address is held, then fetching resumes at the new pc.
- A redirect coincident with an ack drops that ack's data.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.
- redirect_pc[1:0] is forced to 2'b00.

## Timing
- Reset values:
  - pc = RESET_PC; if_pc = if_pc4 = if_inst = 0; if_valid = 0.
  - State = FETCH, drop flag = 0.
  - imem_req = 1 from the first cycle after clrn rises.
- Latency: with a zero-wait memory (ack in the request cycle), an instruction appears in IF/ID at the next rising edge. Throughput is one instruction per cycle.
- Redirect: the target fetch is issued in the cycle after the redirect edge. Exactly one wrong-path slot is squashed (if_valid=0).
- Reset asserted mid-WAIT abandons the request; the memory must tolerate req being dropped.
- If_* outputs are registered; imem_req and imem_addr are Moore outputs of state and pc.

## Configuration
- PIPE_IF_PERF_EN defined: adds output ports fetch_cnt[31:0] and stall_cnt[31:0], both reset to 0.
  - fetch_cnt increments on every IF/ID load with valid=1.
  - stall_cnt increments every cycle in WAIT or HOLD.
  - Both counters wrap at 2^32.
- PIPE_IF_PERF_EN undefined: the ports and logic are absent; behaviour is otherwise identical.

## Structure
- Shared package pipe_pkg:
  - RESET_PC default and the INST_NOP constant (32'h0).
  - if_state_t enum {FETCH, WAIT, HOLD}.
  - The IF/ID bundle typedef (pc, pc4, inst, valid) reused by the ID stage.
- One natural sub-module, pipe_ifid_reg: IF/ID register with load, flush and hold.
  - Flush takes priority over hold.

## Test plan
- Zero-wait memory, 4 cycles: if_pc = 0, 4, 8, 12 on consecutive cycles with if_valid=1; imem_req is high throughout.
- Ack delayed 2 cycles at addr 0x10: the state passes through WAIT and 2 bubbles appear. if_inst equals rdata at if_pc=0x10, and imem_addr stays 0x10 during the wait.
- id_stall high for 3 cycles while an ack arrives: the state goes to HOLD with imem_req=0 and IF/ID unchanged. On release the buffered word appears with the correct if_pc and the next fetch is pc+4.
- redirect to 0x200 in WAIT, with the ack arriving 1 cycle later:
  - The stale ack data is dropped (if_valid stays 0).
  - The next imem_addr is 0x200; the first valid if_pc is 0x200.
- redirect with id_stall both high: IF/ID is flushed (if_valid=0) and pc=redirect_pc on the next edge.
- clrn pulsed low mid-WAIT: all outputs return to their reset values immediately, and fetching restarts at RESET_PC. With PIPE_IF_PERF_EN, the counters read 0.
